// File: rtl/rd_tracker_pkg.sv
// Shared types and defaults for the rd pending tracker and the rd_out UVC.
package rd_tracker_pkg;

    localparam int unsigned RD_W_DEFAULT  = 5;
    localparam int unsigned DEPTH_DEFAULT = 4;

    typedef logic [RD_W_DEFAULT-1:0] rd_idx_t;

    typedef struct packed {
        logic    we;
        rd_idx_t rd;
    } rd_entry_t;

endpackage

// File: rtl/rd_entry_fifo.sv
// Circular buffer of DEPTH entries with pointers, occupancy and per-slot valid mask.
module rd_entry_fifo #(
    parameter int unsigned W     = 6,
    parameter int unsigned DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        push,
    input  logic [W-1:0]                push_data,
    input  logic                        pop,
    output logic [W-1:0]                head,
    output logic [DEPTH-1:0][W-1:0]     entries,
    output logic [DEPTH-1:0]            valid,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        full,
    output logic                        empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DEPTH-1:0][W-1:0] mem;
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic                    do_push;
    logic                    do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign entries = mem;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

    // A slot is live when its distance from the head (mod DEPTH) is below the occupancy.
    always_comb begin
        valid = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] off;
            off      = PW'(i) - rd_ptr;
            valid[i] = (CW'(off) < count);
        end
    end

endmodule

// File: rtl/rd_pending_tracker.sv
// In-order tracker of pending destination registers with RAW hazard lookup.
// Optional stall counter enabled by RD_PENDING_TRACKER_STATS_EN.
module rd_pending_tracker
    import rd_tracker_pkg::*;
#(
    parameter int unsigned RD_W  = RD_W_DEFAULT,
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    issue_valid,
    output logic                    issue_ready,
    input  logic                    issue_we,
    input  logic [RD_W-1:0]         issue_rd,
    input  logic                    retire_valid,
    output logic [RD_W-1:0]         retire_rd,
    output logic                    retire_we,
    input  logic [RD_W-1:0]         rs1_addr,
    input  logic [RD_W-1:0]         rs2_addr,
    output logic                    rs1_hazard,
    output logic                    rs2_hazard,
    output logic [(2**RD_W)-1:0]    pending_map,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty,
    output logic                    full
`ifdef RD_PENDING_TRACKER_STATS_EN
    ,
    output logic [15:0]             stall_cnt
`endif
);

    localparam int unsigned EW = RD_W + 1;

    logic                      push;
    logic                      pop;
    logic [EW-1:0]             push_entry;
    logic [EW-1:0]             head;
    logic [DEPTH-1:0][EW-1:0]  entries;
    logic [DEPTH-1:0]          valid;

    assign issue_ready = !full;
    // Flush wins: neither the offered entry nor the retire reaches the buffer.
    assign push        = issue_valid && issue_ready && !flush;
    assign pop         = retire_valid && !empty && !flush;
    assign push_entry  = {issue_we && (issue_rd != '0), issue_rd};

    rd_entry_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (flush),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .entries   (entries),
        .valid     (valid),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign retire_we = head[RD_W];
    assign retire_rd = head[RD_W-1:0];

    always_comb begin
        pending_map = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid[i] && entries[i][RD_W]) begin
                pending_map[entries[i][RD_W-1:0]] = 1'b1;
            end
        end
    end

    assign rs1_hazard = pending_map[rs1_addr];
    assign rs2_hazard = pending_map[rs2_addr];

`ifdef RD_PENDING_TRACKER_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            stall_cnt <= '0;
        end else if (issue_valid && !issue_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rd_pending_tracker.sv
// Self-checking bench: directed vector table plus randomized run against a queue model.
module tb_rd_pending_tracker;

    localparam int unsigned RD_W  = 5;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic        issue_we = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        retire_valid = 1'b0;
    logic [4:0]  retire_rd;
    logic        retire_we;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic        rs1_hazard;
    logic        rs2_hazard;
    logic [31:0] pending_map;
    logic [2:0]  count;
    logic        empty;
    logic        full;
`ifdef RD_PENDING_TRACKER_STATS_EN
    logic [15:0] stall_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rd_pending_tracker #(
        .RD_W  (RD_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_we     (issue_we),
        .issue_rd     (issue_rd),
        .retire_valid (retire_valid),
        .retire_rd    (retire_rd),
        .retire_we    (retire_we),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_hazard   (rs1_hazard),
        .rs2_hazard   (rs2_hazard),
        .pending_map  (pending_map),
        .count        (count),
        .empty        (empty),
        .full         (full)
`ifdef RD_PENDING_TRACKER_STATS_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        fl, iv, we;
        logic [4:0]  rd;
        logic        rv;
        logic [4:0]  r1, r2;
        int          cnt;
        logic [31:0] map;
        logic [4:0]  hrd;
        logic        hwe;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic fl, iv, we, input int rd, input logic rv,
                       input int r1, r2, cnt, input logic [31:0] map, input int hrd, input logic hwe);
        vec_t v;
        v.fl = fl; v.iv = iv; v.we = we; v.rd = 5'(rd); v.rv = rv;
        v.r1 = 5'(r1); v.r2 = 5'(r2); v.cnt = cnt; v.map = map; v.hrd = 5'(hrd); v.hwe = hwe;
        vecs.push_back(v);
    endtask

    // Reference model: ordered list of {we, rd} in flight.
    typedef struct { logic we; logic [4:0] rd; } ent_t;
    ent_t q[$];
    int   m_stall;

    function automatic logic [31:0] model_map();
        logic [31:0] m = '0;
        foreach (q[i]) if (q[i].we) m[q[i].rd] = 1'b1;
        return m;
    endfunction

    task automatic model_step();
        int sz = q.size();
        bit ovf = issue_valid && (sz == DEPTH);
        if (!rst_n || flush) begin
            q.delete();
            m_stall = 0;
            return;
        end
        if (ovf && m_stall < 65535) m_stall++;
        if (retire_valid && sz > 0) void'(q.pop_front());
        if (issue_valid && sz < DEPTH) begin
            ent_t e;
            e.we = issue_we && (issue_rd != 0);
            e.rd = issue_rd;
            q.push_back(e);
        end
    endtask

    task automatic check_vs_model(input string tag);
        logic [31:0] m = model_map();
        int sz = q.size();
        chk({tag, "_count"}, 32'(count), 32'(sz));
        chk({tag, "_map"}, pending_map, m);
        chk({tag, "_empty"}, 32'(empty), 32'(sz == 0));
        chk({tag, "_full"}, 32'(full), 32'(sz == DEPTH));
        chk({tag, "_ready"}, 32'(issue_ready), 32'(sz != DEPTH));
        chk({tag, "_rd"}, 32'(retire_rd), sz > 0 ? 32'(q[0].rd) : 32'd0);
        chk({tag, "_we"}, 32'(retire_we), sz > 0 ? 32'(q[0].we) : 32'd0);
        chk({tag, "_h1"}, 32'(rs1_hazard), 32'(m[rs1_addr]));
        chk({tag, "_h2"}, 32'(rs2_hazard), 32'(m[rs2_addr]));
`ifdef RD_PENDING_TRACKER_STATS_EN
        chk({tag, "_stall"}, 32'(stall_cnt), 32'(m_stall));
`endif
    endtask

    initial begin
        // Reset held for two edges.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_map", pending_map, 32'h0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ready", 32'(issue_ready), 32'd1);
        chk("rst_we", 32'(retire_we), 32'd0);
        chk("rst_rd", 32'(retire_rd), 32'd0);
        rst_n = 1'b1;

        //   fl iv we rd rv  r1 r2 cnt map       hrd hwe
        add(0, 1, 1, 5, 0,  5, 6, 1, 32'h20,   5, 1);
        add(0, 0, 0, 0, 1,  5, 6, 0, 32'h0,    0, 0);
        add(0, 1, 1, 0, 0,  0, 0, 1, 32'h0,    0, 0);
        add(0, 0, 0, 0, 1,  0, 0, 0, 32'h0,    0, 0);
        add(0, 1, 1, 1, 0,  4, 1, 1, 32'h2,    1, 1);
        add(0, 1, 1, 2, 0,  4, 1, 2, 32'h6,    1, 1);
        add(0, 1, 1, 3, 0,  4, 1, 3, 32'hE,    1, 1);
        add(0, 1, 1, 4, 0,  4, 1, 4, 32'h1E,   1, 1);
        add(0, 1, 1, 9, 1,  4, 1, 3, 32'h1C,   2, 1);
        add(0, 0, 0, 0, 1,  4, 3, 2, 32'h18,   3, 1);
        add(0, 0, 0, 0, 1,  4, 3, 1, 32'h10,   4, 1);
        add(0, 0, 0, 0, 1,  4, 3, 0, 32'h0,    0, 0);
        add(0, 1, 1, 7, 0,  7, 0, 1, 32'h80,   7, 1);
        add(0, 1, 1, 7, 0,  7, 0, 2, 32'h80,   7, 1);
        add(0, 0, 0, 0, 1,  7, 0, 1, 32'h80,   7, 1);
        add(0, 0, 0, 0, 1,  7, 0, 0, 32'h0,    0, 0);
        add(0, 1, 1, 6, 0,  6, 8, 1, 32'h40,   6, 1);
        add(0, 1, 1, 8, 1,  6, 8, 1, 32'h100,  8, 1);
        add(0, 1, 0, 10, 0, 10, 8, 2, 32'h100, 8, 1);
        add(0, 1, 1, 11, 0, 11, 8, 3, 32'h900, 8, 1);
        add(1, 1, 1, 12, 1, 11, 12, 0, 32'h0,  0, 0);
        add(0, 0, 0, 0, 1,  0, 0, 0, 32'h0,    0, 0);

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            flush = vecs[i].fl; issue_valid = vecs[i].iv; issue_we = vecs[i].we;
            issue_rd = vecs[i].rd; retire_valid = vecs[i].rv;
            rs1_addr = vecs[i].r1; rs2_addr = vecs[i].r2;
            @(posedge clk); #1;
            flush = 1'b0; issue_valid = 1'b0; retire_valid = 1'b0;
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].cnt));
            chk($sformatf("v%0d_map", i), pending_map, vecs[i].map);
            chk($sformatf("v%0d_rd", i), 32'(retire_rd), 32'(vecs[i].hrd));
            chk($sformatf("v%0d_we", i), 32'(retire_we), 32'(vecs[i].hwe));
            chk($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].cnt == DEPTH));
            chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].cnt == 0));
            chk($sformatf("v%0d_h1", i), 32'(rs1_hazard), 32'(vecs[i].map[vecs[i].r1]));
            chk($sformatf("v%0d_h2", i), 32'(rs2_hazard), 32'(vecs[i].map[vecs[i].r2]));
        end

        // Mid-operation reset after filling a couple of entries.
        @(posedge clk); #1;
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd3;
        repeat (2) @(posedge clk);
        #1;
        issue_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_map", pending_map, 32'h0);

`ifdef RD_PENDING_TRACKER_STATS_EN
        // Saturation: hold a full tracker with a blocked issue for >65535 cycles.
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd9;
        repeat (DEPTH) @(posedge clk);
        #1;
        chk("stat_zero_at_full", 32'(stall_cnt), 32'd0);
        repeat (65540) @(posedge clk);
        #1;
        chk("stat_sat", 32'(stall_cnt), 32'hFFFF);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; issue_valid = 1'b0;
        chk("stat_flush", 32'(stall_cnt), 32'd0);
        chk("stat_flush_count", 32'(count), 32'd0);
`endif

        // Randomized run against the queue model.
        q.delete();
        m_stall = 0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            rst_n        = ($urandom_range(0, 199) != 0);
            flush        = ($urandom_range(0, 49) == 0);
            issue_valid  = ($urandom_range(0, 99) < 60);
            issue_we     = ($urandom_range(0, 9) != 0);
            issue_rd     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            retire_valid = ($urandom_range(0, 99) < 45);
            rs1_addr     = 5'($urandom_range(0, 31));
            rs2_addr     = (q.size() > 0 && $urandom_range(0, 1) == 1) ? q[0].rd
                                                                         : 5'($urandom_range(0, 31));
            #3;
            check_vs_model("rnd");
            model_step();
            @(posedge clk); #1;
        end
        rst_n = 1'b1; flush = 1'b0; issue_valid = 1'b0; retire_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
